mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between two requesters: instruction fetch (read-only)
//  and the load/store path (memory stage). One transaction in flight at a time.
//  Load/store has priority; a starvation counter guarantees fetch progress.
//  Sits between the pipeline stages and the memory, driving its enable/write/address/data lines.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width; byte-enable width is DATA_W/8
//  MEM_LATENCY   1   cycles from ISSUE cycle to mem_rdata valid (>=1)
//  STARVE_LIMIT  4   consecutive LS grants while fetch waits before fetch is forced (>=1)
// PORTS
//  clock      in   1         rising-edge clock
//  reset      in   1         synchronous, active-high
//  if_req     in   1         fetch request; hold with if_addr until if_gnt
//  if_addr    in   ADDR_W    fetch address
//  if_gnt     out  1         fetch request accepted this cycle
//  if_rvalid  out  1         fetch read data valid (1-cycle pulse)
//  if_rdata   out  DATA_W    fetch read data, 0 when if_rvalid=0
//  ls_req     in   1         load/store request; hold payload until ls_gnt
//  ls_we      in   1         1=store, 0=load
//  ls_addr    in   ADDR_W    load/store address
//  ls_wdata   in   DATA_W    store data
//  ls_be      in   DATA_W/8  store byte enables
//  ls_gnt     out  1         load/store request accepted this cycle
//  ls_rvalid  out  1         load data valid / store complete (1-cycle pulse)
//  ls_rdata   out  DATA_W    load data; 0 for stores and when ls_rvalid=0
//  mem_enable out  1         memory access strobe
//  mem_we     out  1         1=write, 0=read
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_be     out  DATA_W/8  memory byte enables
//  mem_rdata  in   DATA_W    memory read data
//  busy       out  1         1 whenever state != IDLE
// BEHAVIOUR
//  Clocking/reset: one clock; reset is synchronous and active-high. Reset forces state=IDLE,
//   streak=0, owner=IF, all mem_* outputs, gnt/rvalid/rdata and busy to 0.
//  FSM: IDLE -> ISSUE -> [WAIT x (MEM_LATENCY-1)] -> RESP -> IDLE.
//  IDLE: gnt is combinational, asserted only here. Winner is LS if ls_req and
//   !(if_req && streak==STARVE_LIMIT); else IF if if_req. Payload latched at the gnt edge.
//   Next state is ISSUE. Fetch is latched with we=0 and be=all-ones.
//  ISSUE: mem_enable=1 for exactly one cycle; mem_we/addr/wdata/be come from latched regs.
//   Outside ISSUE, all mem_* outputs are 0.
//  WAIT: down-counter loaded with MEM_LATENCY-1; go to RESP when it reaches 0.
//   MEM_LATENCY=1 means ISSUE goes straight to RESP.
//  RESP: owner's rvalid=1; rdata = mem_rdata passthrough (0 for a store). Next state is IDLE.
//   No grant in RESP. Throughput: one transaction per MEM_LATENCY+2 cycles.
//  Starvation: on an LS grant with if_req=1, streak++ (saturating at STARVE_LIMIT).
//   On an IF grant, streak=0. An LS grant with if_req=0 leaves streak unchanged.
//  Requester may drop or change req after gnt; in-flight transaction unaffected.
//   A new req during the busy cycles is ignored until IDLE.
//  Reset mid-transaction: the in-flight access is abandoned and no rvalid is produced.
//   mem_enable is 0 from the cycle after reset is sampled.
//  Simultaneous events: only one gnt ever per cycle; gnt and rvalid are never both high
//   (different states).
// TESTING
//  1 Single load: ls_req, ls_addr=0x100, MEM_LATENCY=1, mem_rdata=0xDEADBEEF ->
//    ls_gnt at c0, mem_enable/we=0/addr=0x100 at c1, ls_rvalid with rdata 0xDEADBEEF at c2,
//    busy=0 at c3.
//  2 Store: ls_we=1, addr=0x20, wdata=0x12345678, be=4'b0011 -> single mem_enable cycle with
//    mem_we=1 and the same data/be; ls_rvalid=1 with ls_rdata=0.
//  3 Contention: if_req and ls_req both held, STARVE_LIMIT=4 -> grants LS,LS,LS,LS,IF,LS...;
//    streak resets after the IF grant.
//  4 Latency: MEM_LATENCY=3 fetch of 0x40 -> if_rvalid exactly 3 cycles after ISSUE;
//    busy high for 4 cycles.
//  5 Reset in WAIT (MEM_LATENCY=3) -> no rvalid; all outputs 0; next request granted
//    normally from IDLE.
//  6 Idle/no-op: no requests for 20 cycles -> mem_enable, gnt, rvalid and busy stay 0;
//    streak unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store,
// one transaction in flight, load/store priority with a starvation guard for fetch.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_be_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                mem_enable_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [SW-1:0]       streak_q;
    logic                owner_ls_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;

    logic idle, issue, resp, ls_win, if_win;

    // Outputs are gated by reset so the reset cycle itself shows all zeros.
    assign idle   = state_q == IDLE && !rst_i;
    assign issue  = state_q == ISSUE && !rst_i;
    assign resp   = state_q == RESP && !rst_i;
    assign ls_win = idle && ls_req_i && !(if_req_i && streak_q == SW'(STARVE_LIMIT));
    assign if_win = idle && if_req_i && !ls_win;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            owner_ls_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (ls_win || if_win) begin
                    state_q    <= ISSUE;
                    owner_ls_q <= ls_win;
                    we_q       <= ls_win && ls_we_i;
                    addr_q     <= ls_win ? ls_addr_i : if_addr_i;
                    wdata_q    <= ls_win ? ls_wdata_i : '0;
                    be_q       <= ls_win ? ls_be_i : '1;
                    if (if_win)
                        streak_q <= '0;
                    else if (if_req_i && streak_q != SW'(STARVE_LIMIT))
                        streak_q <= streak_q + 1'b1;
                end
                ISSUE: begin
                    state_q <= MEM_LATENCY == 1 ? RESP : WAIT;
                    cnt_q   <= CW'(MEM_LATENCY - 1);
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1))
                        state_q <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_gnt_o     = if_win;
    assign ls_gnt_o     = ls_win;
    assign mem_enable_o = issue;
    assign mem_we_o     = issue && we_q;
    assign mem_addr_o   = issue ? addr_q : '0;
    assign mem_wdata_o  = issue ? wdata_q : '0;
    assign mem_be_o     = issue ? be_q : '0;
    assign if_rvalid_o  = resp && !owner_ls_q;
    assign ls_rvalid_o  = resp && owner_ls_q;
    assign if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
    assign ls_rdata_o   = ls_rvalid_o && !we_q ? mem_rdata_i : '0;
    assign busy_o       = state_q != IDLE && !rst_i;
endmodule
